// File: rtl/wbcsram_if.sv
// Wishbone classic bus bundle between a crossbar master port and the wbcsram slave.
interface wbcsram_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [SW-1:0] sel;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;

  modport master (
    output cyc, stb, we, addr, data, sel,
    input  ack, err, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, data, sel,
    output ack, err, rdata
  );
endinterface

// File: rtl/wbcsram.sv
// Wishbone classic slave around a word-addressed RAM with byte lanes, programmable
// wait states and an error response for accesses outside the decoded window.
module wbcsram #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int SW          = DW / 8,
  parameter int DEPTH       = 1024,
  parameter int DECODE_BITS = 24,
  parameter int WAIT_STATES = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  wbcsram_if.slave   bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int LS = $clog2(SW);

  // Address bits between the word index and the decode limit must all be zero.
  localparam logic [AW-1:0] DecMask = (DECODE_BITS >= AW) ? '1
                                    : ((AW'(1) << DECODE_BITS) - AW'(1));
  localparam logic [AW-1:0] LoMask  = (AW'(1) << (LS + IW)) - AW'(1);
  localparam logic [AW-1:0] OorMask = DecMask & ~LoMask;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept;
  logic          enter_resp;

  logic [IW-1:0] idx_q;
  logic [DW-1:0] data_q;
  logic [SW-1:0] sel_q;
  logic          we_q;
  logic          oor_q;

  logic [IW-1:0] acc_idx;
  logic [DW-1:0] acc_data;
  logic [SW-1:0] acc_sel;
  logic          acc_we;
  logic          acc_oor;

  logic          req;
  logic          bus_oor;

  logic          ack_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;

  logic [DW-1:0] mem [DEPTH];

  assign req     = bus.cyc & bus.stb;
  assign bus_oor = |(bus.addr & OorMask);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d    = StResp;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge itself.
  always_comb begin
    if (state_q == StIdle) begin
      acc_idx  = bus.addr[LS+IW-1:LS];
      acc_data = bus.data;
      acc_sel  = bus.sel;
      acc_we   = bus.we;
      acc_oor  = bus_oor;
    end else begin
      acc_idx  = idx_q;
      acc_data = data_q;
      acc_sel  = sel_q;
      acc_we   = we_q;
      acc_oor  = oor_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_resp & ~acc_oor;
      err_q   <= enter_resp & acc_oor;
      rdata_q <= (enter_resp && !acc_we && !acc_oor) ? mem[acc_idx] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      idx_q  <= bus.addr[LS+IW-1:LS];
      data_q <= bus.data;
      sel_q  <= bus.sel;
      we_q   <= bus.we;
      oor_q  <= bus_oor;
    end
  end

  // RAM is not reset; a reset edge simply blocks the commit.
  always_ff @(posedge i_clk) begin
    if (!i_reset && enter_resp && acc_we && !acc_oor) begin
      for (int n = 0; n < SW; n++) begin
        if (acc_sel[n]) mem[acc_idx][8*n +: 8] <= acc_data[8*n +: 8];
      end
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_wbcsram.sv
// Directed bench for wbcsram: three instances (0, 3 and 2 wait states) share one
// stimulus driver, gated so only the selected instance sees a bus cycle.
module tb_wbcsram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  sel   = '0;
  int          cur   = 0;

  logic        ack_m;
  logic        err_m;
  logic [31:0] rdata_m;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wbcsram_if #(.AW(32), .DW(32)) bus0 ();
  wbcsram_if #(.AW(32), .DW(32)) bus3 ();
  wbcsram_if #(.AW(32), .DW(32)) bus2 ();

  assign bus0.cyc  = (cur == 0) & cyc;
  assign bus0.stb  = (cur == 0) & stb;
  assign bus0.we   = we;
  assign bus0.addr = addr;
  assign bus0.data = wdata;
  assign bus0.sel  = sel;
  assign bus3.cyc  = (cur == 3) & cyc;
  assign bus3.stb  = (cur == 3) & stb;
  assign bus3.we   = we;
  assign bus3.addr = addr;
  assign bus3.data = wdata;
  assign bus3.sel  = sel;
  assign bus2.cyc  = (cur == 2) & cyc;
  assign bus2.stb  = (cur == 2) & stb;
  assign bus2.we   = we;
  assign bus2.addr = addr;
  assign bus2.data = wdata;
  assign bus2.sel  = sel;

  wbcsram #(.WAIT_STATES(0)) u_ws0 (.i_clk(clk), .i_reset(rst), .bus(bus0));
  wbcsram #(.WAIT_STATES(3)) u_ws3 (.i_clk(clk), .i_reset(rst), .bus(bus3));
  wbcsram #(.WAIT_STATES(2)) u_ws2 (.i_clk(clk), .i_reset(rst), .bus(bus2));

  always_comb begin
    ack_m   = bus0.ack;
    err_m   = bus0.err;
    rdata_m = bus0.rdata;
    if (cur == 3) begin
      ack_m   = bus3.ack;
      err_m   = bus3.err;
      rdata_m = bus3.rdata;
    end else if (cur == 2) begin
      ack_m   = bus2.ack;
      err_m   = bus2.err;
      rdata_m = bus2.rdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer; lat counts edges from presentation until a response is visible.
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic g_ack, output logic g_err,
                          output logic [31:0] g_data, output int lat);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    g_ack = 1'b0; g_err = 1'b0; g_data = '0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ack_m || err_m) begin
        g_ack = ack_m; g_err = err_m; g_data = rdata_m; lat = i;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (lat == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL xfer_timeout: no response within 40 cycles, addr=%h", a);
    end
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    tick(); tick();
    v = {29'd0, bus0.ack | bus3.ack | bus2.ack, bus0.err | bus3.err | bus2.err, 1'b0};
    n_cmp++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL reset_ack_err: got %h want 0", v); end
    n_cmp++;
    if ((bus0.rdata | bus3.rdata | bus2.rdata) !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", bus0.rdata | bus3.rdata | bus2.rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_collision();
    logic ga, ge; logic [31:0] gd; int lat;
    cur = 0;
    bus_xfer(1'b1, 32'h40, 32'h0000_0001, 4'hF, ga, ge, gd, lat);
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h55; sel = 4'hF;
    tick();
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    n_cmp++;
    if (ack_m !== 1'b0) begin n_fail++; $display("FAIL collide_ack: got %b want 0", ack_m); end
    bus_xfer(1'b0, 32'h40, 32'h0, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if (gd !== 32'h1) begin n_fail++; $display("FAIL collide_nowrite: got %h want 00000001", gd); end
  endtask

  task automatic test_rw();
    logic ga, ge; logic [31:0] gd; int lat;
    cur = 0;
    bus_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if ({ga, ge} !== 2'b10) begin n_fail++; $display("FAIL rw_write_ack: got %b%b want 10", ga, ge); end
    n_cmp++;
    if (lat !== 1) begin n_fail++; $display("FAIL rw_write_lat: got %0d want 1", lat); end
    n_cmp++;
    if (rdata_m !== 32'd0) begin n_fail++; $display("FAIL rw_idle_data: got %h want 0", rdata_m); end
    bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if (gd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_read: got %h want deadbeef", gd); end
    n_cmp++;
    if (lat !== 1) begin n_fail++; $display("FAIL rw_read_lat: got %0d want 1", lat); end
    n_cmp++;
    if (rdata_m !== 32'd0) begin n_fail++; $display("FAIL rw_post_data: got %h want 0", rdata_m); end
    bus_xfer(1'b0, 32'h13, 32'h0, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if (gd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_misalign: got %h want deadbeef", gd); end
  endtask

  task automatic test_byte_lanes();
    logic ga, ge; logic [31:0] gd; int lat;
    cur = 0;
    bus_xfer(1'b1, 32'h30, 32'h1122_3344, 4'hF, ga, ge, gd, lat);
    bus_xfer(1'b1, 32'h30, 32'hAABB_CCDD, 4'h5, ga, ge, gd, lat);
    bus_xfer(1'b0, 32'h30, 32'h0, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if (gd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL lanes_sel5: got %h want 11bb33dd", gd); end
    bus_xfer(1'b1, 32'h30, 32'hFFFF_FFFF, 4'h0, ga, ge, gd, lat);
    n_cmp++;
    if (ga !== 1'b1) begin n_fail++; $display("FAIL lanes_sel0_ack: got %b want 1", ga); end
    bus_xfer(1'b0, 32'h30, 32'h0, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if (gd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL lanes_sel0: got %h want 11bb33dd", gd); end
  endtask

  // Hold stb with a fixed read and record the edge number of three consecutive acks.
  task automatic test_back_to_back(input int which, input int period);
    int t[3]; int k;
    cur = which; k = 0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF;
    for (int i = 1; i <= 60 && k < 3; i++) begin
      tick();
      if (ack_m) begin t[k] = i; k++; end
    end
    cyc = 1'b0; stb = 1'b0;
    tick();
    n_cmp++;
    if (k !== 3) begin n_fail++; $display("FAIL b2b_count_ws%0d: got %0d acks want 3", which, k); end
    n_cmp++;
    if ((t[1] - t[0]) !== period || (t[2] - t[1]) !== period) begin
      n_fail++;
      $display("FAIL b2b_period_ws%0d: got %0d,%0d want %0d", which, t[1] - t[0], t[2] - t[1],
               period);
    end
  endtask

  task automatic test_wait_states();
    logic ga, ge; logic [31:0] gd; int lat;
    cur = 3;
    bus_xfer(1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("FAIL ws3_write_lat: got %0d want 4", lat); end
    bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if (lat !== 4 || gd !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL ws3_read: got lat %0d data %h want 4 0badf00d", lat, gd);
    end
  endtask

  task automatic test_error();
    logic ga, ge; logic [31:0] gd; int lat;
    cur = 0;
    bus_xfer(1'b1, 32'h0, 32'h0000_00A5, 4'hF, ga, ge, gd, lat);
    bus_xfer(1'b1, 32'h1000, 32'h1234_5678, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if ({ga, ge} !== 2'b01 || gd !== 32'd0) begin
      n_fail++; $display("FAIL err_resp: got ack%b err%b data %h want 0 1 0", ga, ge, gd);
    end
    bus_xfer(1'b0, 32'h0, 32'h0, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if (gd !== 32'h0000_00A5) begin n_fail++; $display("FAIL err_nowrite: got %h want a5", gd); end
    bus_xfer(1'b0, 32'h0100_0000, 32'h0, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if ({ga, ge} !== 2'b10 || gd !== 32'h0000_00A5) begin
      n_fail++; $display("FAIL err_highbits: got ack%b err%b data %h want 1 0 a5", ga, ge, gd);
    end
  endtask

  task automatic test_abort();
    logic ga, ge; logic [31:0] gd; int lat; int seen;
    cur = 2; seen = 0;
    bus_xfer(1'b1, 32'h20, 32'h600D_CAFE, 4'hF, ga, ge, gd, lat);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D; sel = 4'hF;
    tick();
    stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack_m || err_m) seen++;
    end
    cyc = 1'b0; we = 1'b0;
    n_cmp++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_resp: got %0d responses want 0", seen); end
    bus_xfer(1'b0, 32'h20, 32'h0, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if (gd !== 32'h600D_CAFE) begin n_fail++; $display("FAIL abort_nowrite: got %h want 600dcafe", gd); end
  endtask

  task automatic test_reset_mid();
    logic ga, ge; logic [31:0] gd; int lat; int seen;
    cur = 3; seen = 0;
    bus_xfer(1'b1, 32'h44, 32'h1357_9BDF, 4'hF, ga, ge, gd, lat);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h44; wdata = 32'h2468_ACE0; sel = 4'hF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (ack_m || err_m) seen++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack_m || err_m) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_fail++; $display("FAIL rstmid_resp: got %0d responses want 0", seen); end
    bus_xfer(1'b0, 32'h44, 32'h0, 4'hF, ga, ge, gd, lat);
    n_cmp++;
    if (gd !== 32'h1357_9BDF || lat !== 4) begin
      n_fail++; $display("FAIL rstmid_after: got %h lat %0d want 13579bdf lat 4", gd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_reset_collision();
    test_rw();
    test_byte_lanes();
    test_back_to_back(0, 2);
    test_wait_states();
    test_back_to_back(3, 5);
    test_error();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
